// File: rtl/oled_power_sequencer_pkg.sv
// Shared types and constants for the OLED power sequencer.
//   state_t         : sequencer states
//   pins_t          : power/reset pin bundle driven per state
//   INIT_ROM        : SSD1306 init bytes, sent in order after reset
//   CMD_DISPLAY_*   : display on/off opcodes
package oled_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned CNT_W            = 32;
  localparam int unsigned INIT_LEN_DEFAULT = 8;
  localparam int unsigned IDX_W            = 3;

  localparam logic [BYTE_W-1:0] CMD_DISPLAY_ON  = 8'hAF;
  localparam logic [BYTE_W-1:0] CMD_DISPLAY_OFF = 8'hAE;

  localparam logic [0:INIT_LEN_DEFAULT-1][BYTE_W-1:0] INIT_ROM =
    {8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hA4};

  typedef enum logic [3:0] {
    S_OFF,
    S_VDD_ON,
    S_RES_LOW,
    S_RES_HIGH,
    S_INIT,
    S_VBAT_ON,
    S_DISP_ON,
    S_READY,
    S_DISP_OFF,
    S_DRAIN,
    S_VBAT_OFF
  } state_t;

  typedef struct packed {
    logic vdd;
    logic vbat;
    logic res;
  } pins_t;

  // Init byte lookup.
  function automatic logic [BYTE_W-1:0] init_byte(input logic [IDX_W-1:0] i);
    return INIT_ROM[i];
  endfunction

  // Pin levels held while in a given state.
  function automatic pins_t pins_for(input state_t s);
    pins_t p;
    p = '0;
    case (s)
      S_OFF:      p = '{vdd: 1'b0, vbat: 1'b0, res: 1'b0};
      S_VDD_ON:   p = '{vdd: 1'b1, vbat: 1'b0, res: 1'b1};
      S_RES_LOW:  p = '{vdd: 1'b1, vbat: 1'b0, res: 1'b0};
      S_RES_HIGH,
      S_INIT:     p = '{vdd: 1'b1, vbat: 1'b0, res: 1'b1};
      S_VBAT_OFF: p = '{vdd: 1'b1, vbat: 1'b0, res: 1'b1};
      default:    p = '{vdd: 1'b1, vbat: 1'b1, res: 1'b1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/oled_power_sequencer_if.sv
// User command stream and transmitter byte stream.
//   master : sequencer side (consumes cmd_*, drives tx_*)
//   slave  : environment side (user source + SPI byte transmitter)
interface oled_power_sequencer_if;
  import oled_pkg::*;

  logic              cmd_valid;
  logic [BYTE_W-1:0] cmd_byte;
  logic              cmd_dc;
  logic              cmd_ready;
  logic              tx_valid;
  logic [BYTE_W-1:0] tx_byte;
  logic              tx_dc;
  logic              tx_ready;
  logic              tx_idle;

  modport master (
    input  cmd_valid, cmd_byte, cmd_dc, tx_ready, tx_idle,
    output cmd_ready, tx_valid, tx_byte, tx_dc
  );

  modport slave (
    output cmd_valid, cmd_byte, cmd_dc, tx_ready, tx_idle,
    input  cmd_ready, tx_valid, tx_byte, tx_dc
  );
endinterface

// File: rtl/oled_delay_timer.sv
// Load/count-down timer. Loading N-1 makes done rise after exactly N cycles.
//   load/load_val : reload counter
//   done          : counter is zero (registered)
module oled_delay_timer
  import oled_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      done <= 1'b1;
    end else if (load) begin
      cnt  <= load_val;
      done <= (load_val == CNT_W'(0));
    end else if (cnt != CNT_W'(0)) begin
      cnt  <= cnt - CNT_W'(1);
      done <= (cnt == CNT_W'(1));
    end
  end

endmodule

// File: rtl/oled_power_sequencer.sv
// SSD1306-class OLED power sequencer: power-up/down of VDD/VBAT/RES, init
// byte stream, then passthrough of the user stream to the SPI transmitter.
//   clk, reset_n    : clock, async active-low reset
//   start / stop    : power-up / power-down request pulses
//   bus             : cmd_* user stream in, tx_* transmitter stream out
//   oled_vdd/vbat   : power enables; oled_res : panel reset (active low)
//   ready           : sequencer in S_READY
module oled_power_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 20_000_000,
  parameter int unsigned DELAY_VDD_CYC  = CLK_FREQ / 1000,
  parameter int unsigned RES_PULSE_CYC  = CLK_FREQ / 100_000,
  parameter int unsigned DELAY_VBAT_CYC = CLK_FREQ / 10,
  parameter int unsigned INIT_LEN       = INIT_LEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  oled_power_sequencer_if.master bus,
  output logic                   oled_vdd,
  output logic                   oled_vbat,
  output logic                   oled_res,
  output logic                   ready
);

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               stop_pend, stop_pend_d;
  pins_t              pins_q;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_done;
  logic               tx_valid_c;
  logic [BYTE_W-1:0]  tx_byte_c;
  logic               tx_dc_c;
  logic               cmd_ready_c;

  oled_delay_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register; pins and ready are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_OFF;
      idx       <= '0;
      stop_pend <= 1'b0;
      pins_q    <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      stop_pend <= stop_pend_d;
      pins_q    <= pins_for(state_d);
      ready     <= (state_d == S_READY);
    end
  end

  // Next state, timer reloads and transmitter stream.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    stop_pend_d = stop_pend;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tx_valid_c  = 1'b0;
    tx_byte_c   = '0;
    tx_dc_c     = 1'b0;
    cmd_ready_c = 1'b0;

    // A stop during power-up is remembered and honoured once READY is reached.
    if (stop && (state inside {S_VDD_ON, S_RES_LOW, S_RES_HIGH, S_INIT,
                               S_VBAT_ON, S_DISP_ON}))
      stop_pend_d = 1'b1;

    case (state)
      S_OFF: begin
        if (start) begin
          state_d  = S_VDD_ON;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(DELAY_VDD_CYC - 1);
        end
      end
      S_VDD_ON: begin
        if (tmr_done) begin
          state_d  = S_RES_LOW;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RES_PULSE_CYC - 1);
        end
      end
      S_RES_LOW: begin
        if (tmr_done) begin
          state_d  = S_RES_HIGH;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RES_PULSE_CYC - 1);
        end
      end
      S_RES_HIGH: begin
        if (tmr_done) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = init_byte(idx);
        if (bus.tx_ready) begin
          if (idx == IDX_W'(INIT_LEN - 1)) begin
            state_d  = S_VBAT_ON;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(DELAY_VBAT_CYC - 1);
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end
      end
      S_VBAT_ON: begin
        if (tmr_done) state_d = S_DISP_ON;
      end
      S_DISP_ON: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = CMD_DISPLAY_ON;
        if (bus.tx_ready) state_d = S_READY;
      end
      S_READY: begin
        tx_byte_c   = bus.cmd_byte;
        tx_dc_c     = bus.cmd_dc;
        cmd_ready_c = bus.tx_ready & ~stop & ~stop_pend;
        if (stop || stop_pend) begin
          state_d     = S_DISP_OFF;
          stop_pend_d = 1'b0;
        end else begin
          tx_valid_c = bus.cmd_valid;
        end
      end
      S_DISP_OFF: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = CMD_DISPLAY_OFF;
        if (bus.tx_ready) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.tx_idle) begin
          state_d  = S_VBAT_OFF;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(DELAY_VBAT_CYC - 1);
        end
      end
      S_VBAT_OFF: begin
        if (tmr_done) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_byte   = tx_byte_c;
  assign bus.tx_dc     = tx_dc_c;
  assign bus.cmd_ready = cmd_ready_c;
  assign oled_vdd      = pins_q.vdd;
  assign oled_vbat     = pins_q.vbat;
  assign oled_res      = pins_q.res;

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Directed bench for oled_power_sequencer with short delays
// (VDD 10, RES 3, VBAT 20 cycles).
module tb_oled_power_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic stop;
  logic oled_vdd;
  logic oled_vbat;
  logic oled_res;
  logic ready;

  oled_power_sequencer_if bus ();

  oled_power_sequencer #(
    .DELAY_VDD_CYC  (10),
    .RES_PULSE_CYC  (3),
    .DELAY_VBAT_CYC (20)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .bus       (bus),
    .oled_vdd  (oled_vdd),
    .oled_vbat (oled_vbat),
    .oled_res  (oled_res),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom_exp [8] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hA1, 8'hC8, 8'hA4};

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       dc;
    logic       rdy;
    logic       e_v;
    logic [7:0] e_b;
    logic       e_dc;
    logic       e_cr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic cond(input int k);
    case (k)
      0:       return !oled_vdd;
      1:       return oled_vbat;
      2:       return bus.tx_valid && (bus.tx_byte == 8'hAF);
      default: return bus.tx_valid;
    endcase
  endfunction

  // Wait (bounded) for a condition; returns at the negedge where it holds.
  task automatic wait_cond(input int k, input string nm);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      smp();
      if (cond(k)) hit = 1'b1;
      else step();
    end
    chk1(nm, hit, 1'b1);
  endtask

  // Full power-up from S_OFF with tx_ready=1, checked cycle by cycle.
  task automatic powerup_trace(input string nm);
    logic       e_res, e_vbat, e_v, e_rdy;
    logic [7:0] e_b;
    bus.tx_ready = 1'b1;
    bus.tx_idle  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      e_res  = !(c >= 11 && c <= 13);
      e_vbat = (c >= 25);
      e_v    = (c >= 17 && c <= 24) || (c == 45);
      e_rdy  = (c >= 46);
      e_b    = (c == 45) ? 8'hAF : ((c >= 17 && c <= 24) ? rom_exp[c-17] : 8'h00);
      smp();
      chk1({nm, "_vdd"}, oled_vdd, 1'b1);
      chk1({nm, "_res"}, oled_res, e_res);
      chk1({nm, "_vbat"}, oled_vbat, e_vbat);
      chk1({nm, "_tx_valid"}, bus.tx_valid, e_v);
      chk1({nm, "_ready"}, ready, e_rdy);
      chk1({nm, "_cmd_ready"}, bus.cmd_ready, e_rdy);
      if (e_v) begin
        chk8({nm, "_tx_byte"}, bus.tx_byte, e_b);
        chk1({nm, "_tx_dc"}, bus.tx_dc, 1'b0);
      end
      step();
    end
  endtask

  // Power-up with tx_ready toggling; collects accepted bytes and checks holds.
  task automatic powerup_backpressure();
    logic [7:0] got [16];
    int         n;
    logic       hold, done;
    logic [7:0] prev_b;
    n = 0; hold = 1'b0; done = 1'b0; prev_b = 8'h00;
    for (int k = 0; k < 16; k++) got[k] = 8'h00;
    for (int i = 0; i < 200 && !done; i++) begin
      bus.tx_ready = i[0];
      smp();
      if (hold) begin
        chk1("bp_valid_held", bus.tx_valid, 1'b1);
        chk8("bp_byte_held", bus.tx_byte, prev_b);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (n < 16) got[n] = bus.tx_byte;
        n++;
        chk1("bp_dc", bus.tx_dc, 1'b0);
      end
      hold   = bus.tx_valid && !bus.tx_ready;
      prev_b = bus.tx_byte;
      if (ready) done = 1'b1;
      else step();
    end
    chk1("bp_reached_ready", done, 1'b1);
    chki("bp_byte_count", n, 9);
    for (int k = 0; k < 9; k++)
      chk8("bp_byte_order", got[k], (k < 8) ? rom_exp[k] : 8'hAF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'h21, 1'b0, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};

    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'h00;
    bus.cmd_dc    = 1'b0;
    bus.tx_ready  = 1'b1;
    bus.tx_idle   = 1'b1;
    step();
    step();

    // Reset state
    smp();
    chk1("rst_vdd", oled_vdd, 1'b0);
    chk1("rst_vbat", oled_vbat, 1'b0);
    chk1("rst_res", oled_res, 1'b0);
    chk1("rst_tx_valid", bus.tx_valid, 1'b0);
    chk8("rst_tx_byte", bus.tx_byte, 8'h00);
    chk1("rst_tx_dc", bus.tx_dc, 1'b0);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b0);
    reset_n = 1'b1;
    step();

    // Nominal power-up
    powerup_trace("pu");

    // Passthrough table in S_READY
    foreach (vecs[i]) begin
      bus.cmd_valid = vecs[i].v;
      bus.cmd_byte  = vecs[i].b;
      bus.cmd_dc    = vecs[i].dc;
      bus.tx_ready  = vecs[i].rdy;
      smp();
      chk1("pt_tx_valid", bus.tx_valid, vecs[i].e_v);
      chk1("pt_cmd_ready", bus.cmd_ready, vecs[i].e_cr);
      chk1("pt_ready", ready, 1'b1);
      if (vecs[i].e_v) begin
        chk8("pt_tx_byte", bus.tx_byte, vecs[i].e_b);
        chk1("pt_tx_dc", bus.tx_dc, vecs[i].e_dc);
      end
      step();
    end

    // Stop in S_READY with a pending user byte
    bus.tx_idle = 1'b0; bus.tx_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_byte = 8'h77; bus.cmd_dc = 1'b1;
    stop = 1'b1;
    smp();
    chk1("stop_cmd_ready", bus.cmd_ready, 1'b0);
    chk1("stop_tx_valid", bus.tx_valid, 1'b0);
    chk1("stop_ready", ready, 1'b1);
    step();
    stop = 1'b0;
    smp();
    chk1("doff_tx_valid", bus.tx_valid, 1'b1);
    chk8("doff_tx_byte", bus.tx_byte, 8'hAE);
    chk1("doff_tx_dc", bus.tx_dc, 1'b0);
    chk1("doff_ready", ready, 1'b0);
    chk1("doff_cmd_ready", bus.cmd_ready, 1'b0);
    step();
    start = 1'b1;
    smp();
    chk1("drain_tx_valid", bus.tx_valid, 1'b0);
    chk1("drain_vbat", oled_vbat, 1'b1);
    step();
    start = 1'b0;
    smp();
    chk1("drain_wait_vbat", oled_vbat, 1'b1);
    chk1("drain_wait_vdd", oled_vdd, 1'b1);
    step();
    bus.tx_idle = 1'b1;
    smp();
    chk1("drain_idle_vbat", oled_vbat, 1'b1);
    step();
    for (int k = 0; k < 20; k++) begin
      smp();
      chk1("vboff_vbat", oled_vbat, 1'b0);
      chk1("vboff_vdd", oled_vdd, 1'b1);
      chk1("vboff_res", oled_res, 1'b1);
      step();
    end
    smp();
    chk1("off_vdd", oled_vdd, 1'b0);
    chk1("off_res", oled_res, 1'b0);
    chk1("off_vbat", oled_vbat, 1'b0);
    chk1("off_ready", ready, 1'b0);
    step();
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00; bus.cmd_dc = 1'b0;

    // Stop in S_OFF ignored; then start+stop together (start wins) with backpressure
    stop = 1'b1;
    step();
    stop = 1'b0;
    smp();
    chk1("off_stop_vdd", oled_vdd, 1'b0);
    step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    powerup_backpressure();
    step();
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk1("ss_ready_held", ready, 1'b1);
      chk1("ss_no_tx", bus.tx_valid, 1'b0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_cond(0, "pd1_reach_off");
    step();

    // Stop during S_VBAT_ON: finish power-up, one READY cycle, then shutdown
    start = 1'b1;
    step();
    start = 1'b0;
    wait_cond(1, "sv_reach_vbat");
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_cond(2, "sv_reach_af");
    chk1("sv_af_dc", bus.tx_dc, 1'b0);
    chk1("sv_af_ready", ready, 1'b0);
    step();
    bus.cmd_valid = 1'b1; bus.cmd_byte = 8'h12;
    smp();
    chk1("sv_ready_once", ready, 1'b1);
    chk1("sv_ready_tx_valid", bus.tx_valid, 1'b0);
    chk1("sv_ready_cmd_ready", bus.cmd_ready, 1'b0);
    step();
    smp();
    chk1("sv_ready_gone", ready, 1'b0);
    chk1("sv_ae_valid", bus.tx_valid, 1'b1);
    chk8("sv_ae_byte", bus.tx_byte, 8'hAE);
    step();
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00;
    wait_cond(0, "sv_reach_off");
    step();

    // Reset mid-INIT, then full replay
    bus.tx_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_cond(3, "rs_reach_init");
    chk8("rs_first_byte", bus.tx_byte, 8'hAE);
    step();
    bus.tx_ready = 1'b1;
    smp();
    step();
    smp();
    step();
    bus.tx_ready = 1'b0;
    smp();
    chk8("rs_idx2_byte", bus.tx_byte, 8'h14);
    #1;
    reset_n = 1'b0;
    #1;
    chk1("rs_vdd", oled_vdd, 1'b0);
    chk1("rs_vbat", oled_vbat, 1'b0);
    chk1("rs_res", oled_res, 1'b0);
    chk1("rs_tx_valid", bus.tx_valid, 1'b0);
    chk1("rs_ready", ready, 1'b0);
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    powerup_trace("rp");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
